// File: rtl/bz_seq_pkg.sv
// rtl/bz_seq_pkg.sv - shared types, widths and duration helper for the melody sequencer
package bz_seq_pkg;

    localparam int NOTE_W    = 8;
    localparam int IDX_W     = 5;
    localparam int DUR_CNT_W = 24;
    localparam int DEPTH     = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STROBE,
        HOLD,
        GAP,
        FIN
    } state_t;

    // Terminal HOLD count for a note of the given duration code: (dur+1)*tick - 1
    function automatic logic [DUR_CNT_W-1:0] hold_last(input logic [3:0] dur, input int tick_cyc);
        int n;
        n = (int'(dur) + 1) * tick_cyc - 1;
        return DUR_CNT_W'(n);
    endfunction

endpackage

// File: rtl/bz_seq_if.sv
// rtl/bz_seq_if.sv - note-table write port and buzzer drive bundle
interface bz_seq_if;
    import bz_seq_pkg::*;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [NOTE_W-1:0] wr_data;
    logic              bz_wr;
    logic [NOTE_W-1:0] bz_val;

    modport master (output wr_en, wr_addr, wr_data, input bz_wr, bz_val);
    modport slave  (input wr_en, wr_addr, wr_data, output bz_wr, bz_val);
endinterface

// File: rtl/bz_seq_ram.sv
// rtl/bz_seq_ram.sv - 32x8 note table, one write port, one registered read port
module bz_seq_ram
    import bz_seq_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [NOTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [NOTE_W-1:0] rd_data
);

    logic [NOTE_W-1:0] mem [DEPTH];

    // Read sees the pre-write contents when both hit the same address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bz_sequencer.sv
// rtl/bz_sequencer.sv - note-table melody player; BZ_SEQ_LOOP_EN enables song repeat
module bz_sequencer
    import bz_seq_pkg::*;
#(
    parameter int TICK_CYC   = 1000000,
    parameter int GAP_CYC    = 100000,
    parameter int STROBE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play,
    input  logic             stop,
    input  logic             loop,
    input  logic [IDX_W-1:0] last_idx,
    bz_seq_if.slave          bus,
    output logic             busy,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [IDX_W-1:0]      last, last_n;
    logic [IDX_W-1:0]      note_idx_n;
    logic [DUR_CNT_W-1:0]  cnt, cnt_n;
    logic                  bz_wr_q, bz_wr_n;
    logic [NOTE_W-1:0]     bz_val_q, bz_val_n;
    logic                  done_n;
    logic [NOTE_W-1:0]     rd_data;
    logic                  loop_take;

`ifdef BZ_SEQ_LOOP_EN
    assign loop_take = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_take   = 1'b0;
`endif

    bz_seq_ram u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (state == FETCH),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            last     <= '0;
            cnt      <= '0;
            bz_wr_q  <= 1'b0;
            bz_val_q <= '0;
            note_idx <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            last     <= last_n;
            cnt      <= cnt_n;
            bz_wr_q  <= bz_wr_n;
            bz_val_q <= bz_val_n;
            note_idx <= note_idx_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        last_n     = last;
        cnt_n      = cnt;
        bz_wr_n    = bz_wr_q;
        bz_val_n   = bz_val_q;
        note_idx_n = note_idx;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (play && !stop) begin
                    state_n = FETCH;
                    idx_n   = '0;
                    last_n  = last_idx;
                    cnt_n   = '0;
                end
            end
            FETCH: begin
                state_n = STROBE;
                cnt_n   = '0;
            end
            STROBE: begin
                // First STROBE cycle: table data has just landed on rd_data
                if (cnt == '0) begin
                    bz_val_n   = rd_data;
                    note_idx_n = idx;
                    bz_wr_n    = 1'b1;
                    cnt_n      = cnt + DUR_CNT_W'(1);
                end else if (cnt == DUR_CNT_W'(STROBE_CYC)) begin
                    bz_wr_n = 1'b0;
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + DUR_CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == hold_last(bz_val_q[7:4], TICK_CYC)) begin
                    state_n        = GAP;
                    cnt_n          = '0;
                    bz_val_n[3:0]  = 4'h0;
                end else begin
                    cnt_n = cnt + DUR_CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == DUR_CNT_W'(GAP_CYC - 1)) begin
                    cnt_n = '0;
                    if (idx < last) begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = FETCH;
                    end else if (loop_take) begin
                        idx_n   = '0;
                        state_n = FETCH;
                    end else begin
                        state_n = FIN;
                    end
                end else begin
                    cnt_n = cnt + DUR_CNT_W'(1);
                end
            end
            FIN: begin
                state_n  = IDLE;
                done_n   = 1'b1;
                bz_val_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort silences immediately and suppresses the done pulse
        if (stop && state != IDLE) begin
            state_n  = IDLE;
            bz_wr_n  = 1'b0;
            bz_val_n = '0;
            cnt_n    = '0;
            done_n   = 1'b0;
        end
    end

    assign busy       = (state != IDLE);
    assign bus.bz_wr  = bz_wr_q;
    assign bus.bz_val = bz_val_q;

endmodule

// File: tb/tb_bz_sequencer.sv
// tb/tb_bz_sequencer.sv - timeline-model self-checking bench for bz_sequencer
module tb_bz_sequencer;

    localparam int TICK = 4;
    localparam int GAPC = 2;
    localparam int STRB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [4:0] last_idx = '0;
    logic       busy;
    logic [4:0] note_idx;
    logic       done;

    bz_seq_if bus ();

    bz_sequencer #(.TICK_CYC(TICK), .GAP_CYC(GAPC), .STROBE_CYC(STRB)) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .stop     (stop),
        .loop     (loop),
        .last_idx (last_idx),
        .bus      (bus),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef BZ_SEQ_LOOP_EN
    localparam bit LOOP_ON = 1'b1;
`else
    localparam bit LOOP_ON = 1'b0;
`endif

    // Model: each note is a timeline of offsets from its fetch cycle
    logic [7:0] tbl [32];
    logic       m_valid = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_fin   = 1'b0;
    int         t = 0;
    int         h;
    logic [4:0] m_idx = '0, m_last = '0;
    logic [7:0] m_fetch = '0, m_cur = '0;
    logic       e_wr = 1'b0, e_done = 1'b0;
    logic [7:0] e_val = '0;
    logic [4:0] e_idx = '0;

    always @(posedge clk) begin
        e_done = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_fin   = 1'b0;
            e_wr    = 1'b0;
            e_val   = '0;
            e_idx   = '0;
        end else if (m_busy && stop) begin
            m_busy = 1'b0;
            m_fin  = 1'b0;
            e_wr   = 1'b0;
            e_val  = '0;
        end else if (!m_busy) begin
            if (play && !stop) begin
                m_busy = 1'b1;
                m_idx  = '0;
                m_last = last_idx;
                t      = 0;
            end
        end else if (m_fin) begin
            m_fin  = 1'b0;
            m_busy = 1'b0;
            e_done = 1'b1;
            e_val  = '0;
        end else begin
            t++;
            if (t == 1) m_fetch = tbl[m_idx];
            if (t == 2) begin
                m_cur = m_fetch;
                e_idx = m_idx;
            end
            h    = (int'(m_cur[7:4]) + 1) * TICK;
            e_wr = (t >= 2 && t < 2 + STRB);
            if (t >= 2 && t < 2 + STRB + h)
                e_val = m_cur;
            else if (t >= 2 + STRB + h && t < 2 + STRB + h + GAPC)
                e_val = {m_cur[7:4], 4'h0};
            if (t == 2 + STRB + h + GAPC) begin
                if (m_idx < m_last) begin
                    m_idx++;
                    t = 0;
                end else if (LOOP_ON && loop) begin
                    m_idx = '0;
                    t     = 0;
                end else begin
                    m_fin = 1'b1;
                end
            end
        end
        if (bus.wr_en) tbl[bus.wr_addr] = bus.wr_data;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("bz_wr", int'(bus.bz_wr), int'(e_wr));
            chk("bz_val", int'(bus.bz_val), int'(e_val));
            chk("busy", int'(busy), int'(m_busy));
            chk("note_idx", int'(note_idx), int'(e_idx));
            chk("done", int'(done), int'(e_done));
        end
    end

    // Event log of observed strobe edges and done pulses
    logic       prev_wr = 1'b0;
    logic [7:0] falls [$];
    logic [4:0] rises [$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (prev_wr && !bus.bz_wr) falls.push_back(bus.bz_val);
        if (!prev_wr && bus.bz_wr) rises.push_back(note_idx);
        if (done) done_cnt++;
        prev_wr = bus.bz_wr;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_play();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(a);
        bus.wr_data = 8'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        tick(1);
    endtask

    task automatic clear_log();
        falls.delete();
        rises.delete();
        done_cnt = 0;
    endtask

    task automatic chk_falls(input string name, input int a, input int b, input int c);
        chk({name, "_n"}, falls.size(), 3);
        if (falls.size() == 3) begin
            chk({name, "_0"}, int'(falls[0]), a);
            chk({name, "_1"}, int'(falls[1]), b);
            chk({name, "_2"}, int'(falls[2]), c);
        end
    endtask

    initial begin
        int rise_n, done_n;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // 1: reset, with a play pulse while rst is high
        tick(1);
        play = 1'b1;
        tick(1);
        play = 1'b0;
        tick(1);
        chk("rst_bz_wr", int'(bus.bz_wr), 0);
        chk("rst_bz_val", int'(bus.bz_val), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        tick(2);
        chk("rst_play_ignored", int'(busy), 0);

        for (int i = 0; i < 32; i++) wr(i, $urandom_range(0, 255));
        wr(0, 'h01);
        wr(1, 'h16);
        wr(2, 'h20);

        // 2: three-note song with literal timing
        last_idx = 5'd2;
        clear_log();
        pulse_play();
        rise_n = -1;
        done_n = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.bz_wr && rise_n < 0) rise_n = n;
            if (done) begin
                done_n = n;
                chk("done_busy_low", int'(busy), 0);
                break;
            end
        end
        chk("play_to_rise", rise_n, 2);
        chk("play_to_done", done_n, 43);
        tick(2);
        chk_falls("song3", 'h01, 'h16, 'h20);
        chk("song3_done_cnt", done_cnt, 1);

        // 3: stop mid-HOLD of note 1, then restart
        clear_log();
        pulse_play();
        tick(15);
        chk("pre_stop_idx", int'(note_idx), 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_val", int'(bus.bz_val), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_done", int'(done), 0);
        pulse_play();
        tick(2);
        chk("restart_wr", int'(bus.bz_wr), 1);
        chk("restart_idx", int'(note_idx), 0);
        wait_idle(200);
        chk("stop_done_cnt", done_cnt, 1);

        // 4: play while busy ignored, stop beats play
        clear_log();
        pulse_play();
        tick(5);
        pulse_play();
        wait_idle(200);
        chk_falls("busy_play", 'h01, 'h16, 'h20);
        chk("busy_play_done", done_cnt, 1);
        pulse_play();
        tick(5);
        play = 1'b1;
        stop = 1'b1;
        tick(1);
        play = 1'b0;
        stop = 1'b0;
        chk("stop_wins_busy", int'(busy), 0);
        play = 1'b1;
        stop = 1'b1;
        tick(1);
        play = 1'b0;
        stop = 1'b0;
        tick(1);
        chk("stop_wins_idle", int'(busy), 0);

        // 5: rewrite the sounding entry
        clear_log();
        pulse_play();
        tick(15);
        wr(1, 'h0A);
        tick(4);
        chk("rewrite_hold", int'(bus.bz_val), 'h16);
        wait_idle(200);
        chk_falls("rewrite_a", 'h01, 'h16, 'h20);
        clear_log();
        pulse_play();
        wait_idle(200);
        chk_falls("rewrite_b", 'h01, 'h0A, 'h20);
        wr(1, 'h16);

        // single-note song
        clear_log();
        last_idx = 5'd0;
        pulse_play();
        wait_idle(200);
        chk("single_n", falls.size(), 1);
        chk("single_done", done_cnt, 1);

`ifdef BZ_SEQ_LOOP_EN
        // 6: looping, then drop loop
        clear_log();
        last_idx = 5'd1;
        loop     = 1'b1;
        pulse_play();
        for (int n = 0; n < 300 && rises.size() < 4; n++) @(negedge clk);
        chk("loop_no_done", done_cnt, 0);
        loop = 1'b0;
        wait_idle(200);
        chk("loop_rises", rises.size(), 4);
        if (rises.size() == 4) begin
            chk("loop_r0", int'(rises[0]), 0);
            chk("loop_r1", int'(rises[1]), 1);
            chk("loop_r2", int'(rises[2]), 0);
            chk("loop_r3", int'(rises[3]), 1);
        end
        chk("loop_done", done_cnt, 1);
`endif

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 5000; c++) begin
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_addr = 5'($urandom_range(0, 31));
            bus.wr_data = 8'($urandom_range(0, 255));
            play        = ($urandom_range(0, 29) == 0);
            stop        = ($urandom_range(0, 399) == 0);
            rst         = ($urandom_range(0, 1999) == 0);
            loop        = ($urandom_range(0, 3) != 0);
            last_idx    = 5'($urandom_range(0, 7));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        play      = 1'b0;
        rst       = 1'b0;
        stop      = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
